stage_objective_tracker: RTL and testbench
==========================================

# stage_objective_tracker

Tracks kill objectives for the current game stage and raises the one-cycle `win_stage` pulse that advances the stage controller. Sits between the stage controller (source of `enable_monst`/`enable_boss`/`enable_astero`/`stage_num`) and the monster, boss and asteroid modules (sources of hit/destroy events). Loads fresh objectives on every stage entry and tracks the living monster set, boss HP and remaining asteroid quota. Fires `win_stage` once all enabled objectives are met and a post-clear frame delay has elapsed.

## Interface
- MONSTER_COUNT, 16, number of monsters per wave (alive mask width)
- BOSS_HP, 8, boss hit points loaded on stage entry
- ASTERO_GOAL, 10, asteroids to destroy in an asteroid stage
- CLEAR_DELAY, 32, frame ticks between objective completion and `win_stage` (0 allowed)
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- enable_monst  in  1  monster objective active
- enable_boss  in  1  boss objective active
- enable_astero  in  1  asteroid objective active
- stage_num  in  3  current stage, encoded INIT=0, STAGE1..STAGE4=1..4
- frame_tick  in  1  one-cycle pulse per video frame
- monster_hit  in  1  one-cycle pulse: monster `monster_hit_idx` destroyed
- monster_hit_idx  in  $clog2(MONSTER_COUNT)  index of the destroyed monster
- boss_hit  in  1  one-cycle pulse: boss takes 1 damage
- astero_destroyed  in  1  one-cycle pulse: one asteroid destroyed
- win_stage  out  1  one-cycle pulse: stage objectives complete
- monsters_alive  out  MONSTER_COUNT  bit i = monster i alive
- boss_hp  out  $clog2(BOSS_HP+1)  remaining boss HP
- astero_left  out  $clog2(ASTERO_GOAL+1)  remaining asteroid quota

## Operation
- States: IDLE, LOAD, ACTIVE, CLEARED, WIN, WAIT.
- IDLE: all enables low. Any enable high moves to LOAD.
- LOAD (1 cycle):
  - Latch `stage_num`.
  - `monsters_alive` = all ones if `enable_monst`, else 0.
  - `boss_hp` = BOSS_HP if `enable_boss`, else 0.
  - `astero_left` = ASTERO_GOAL if `enable_astero`, else 0.
  - Events in this cycle are dropped. Next state ACTIVE.
- ACTIVE: event updates.
  - `monster_hit` clears bit `monster_hit_idx`. Hits on a dead bit are no-ops. Indices >= MONSTER_COUNT are ignored.
  - `boss_hit` decrements `boss_hp`, saturating at 0.
  - `astero_destroyed` decrements `astero_left`, saturating at 0.
  - Simultaneous events in one cycle are all applied.
- done = (`monsters_alive`==0) && (`boss_hp`==0) && (`astero_left`==0), evaluated on registered values. A disabled objective loads as 0, so it counts as complete.
- ACTIVE and done: go to CLEARED and clear the delay counter.
- CLEARED:
  - Count `frame_tick` pulses. On the CLEAR_DELAY-th tick, go to WIN.
  - With CLEAR_DELAY=0, go to WIN on the next cycle.
  - Events are ignored.
- WIN (1 cycle): `win_stage`=1, then go to WAIT.
- WAIT: hold outputs until `stage_num` differs from the latched value, then go to LOAD (or IDLE if all enables are low). This covers STAGE1->STAGE2 (enables stay high) and STAGE4->STAGE1.
- Global overrides, taking priority over the normal transitions:
  - In LOAD/ACTIVE/CLEARED/WIN/WAIT, all enables low -> IDLE next cycle. Counters keep their values; `win_stage`=0.
  - In ACTIVE or CLEARED, `stage_num` differs from the latched value -> LOAD. This restarts the objective.

## Timing
- Reset values: state IDLE, `win_stage` 0, `monsters_alive` 0, `boss_hp` 0, `astero_left` 0, delay counter 0, latched stage 0.
- All outputs are registered (Moore). `win_stage` is never combinational from inputs.
- A kill event sampled at edge N updates counters at edge N.
- done is visible in cycle N, and the state becomes CLEARED at edge N+1.
- With CLEAR_DELAY=0, WIN is entered at edge N+2 and `win_stage` is high for the cycle after edge N+2.
- Enable rising at edge E:
  - LOAD at E+1, counters loaded at E+2, ACTIVE from E+2.
  - The first accepted event is sampled at E+3.
- Exactly one `win_stage` pulse per stage entry. It cannot repeat while in WAIT.
- A `resetN` assertion mid-stage asynchronously clears all state. No pulse is emitted.

## Structure
- Shared package `game_pkg`:
  - Stage enum (INIT..STAGE4, 3-bit), shared with the stage controller.
  - Default objective constants MONSTER_COUNT, BOSS_HP, ASTERO_GOAL, CLEAR_DELAY.
- Sub-module `frame_delay_counter`:
  - Ports: clear, frame_tick, and a terminal-count flag.
  - Parameter: CLEAR_DELAY.
  - Holds the frame counter used in CLEARED.

## Test plan
- Reset, then `enable_monst`=1 with `stage_num`=1, MONSTER_COUNT=4, CLEAR_DELAY=2. Hit idx 0,1,2,3, plus a duplicate on idx 2. Then give 2 frame ticks -> exactly one `win_stage` pulse, one cycle after the 2nd tick registers.
- Stage 4 with monst+boss, BOSS_HP=3: kill all monsters, apply 2 `boss_hit` -> no win. A 3rd hit and a 4th hit -> `boss_hp` saturates at 0, then a single `win_stage` follows.
- Stage 3, ASTERO_GOAL=10, CLEAR_DELAY=0: 10 `astero_destroyed` pulses, the last at edge N -> `win_stage` high in the cycle after edge N+2.
- After a win pulse, hold `stage_num`=1 for 50 cycles -> no further pulse. Change to 2 -> LOAD, `monsters_alive`=all ones.
- In ACTIVE, drive `monster_hit` and `boss_hit` in the same cycle -> both applied. Drop all enables -> IDLE, `win_stage` stays 0.
- Assert `resetN` low during CLEARED -> all outputs 0 immediately, no `win_stage`.

Source files
------------

// File: rtl/game_pkg.sv
// Types and default objective constants shared by the stage controller and
// the objective tracker.
package game_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    STAGE1 = 3'd1,
    STAGE2 = 3'd2,
    STAGE3 = 3'd3,
    STAGE4 = 3'd4
  } stage_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACTIVE,
    S_CLEARED,
    S_WIN,
    S_WAIT
  } objective_state_e;

  localparam int DEF_MONSTER_COUNT = 16;
  localparam int DEF_BOSS_HP       = 8;
  localparam int DEF_ASTERO_GOAL   = 10;
  localparam int DEF_CLEAR_DELAY   = 32;

endpackage

// File: rtl/frame_delay_counter.sv
// Counts frame ticks after the objectives clear; flags the tick that ends the
// post-clear delay.
module frame_delay_counter
  import game_pkg::*;
#(
  parameter int  CLEAR_DELAY = DEF_CLEAR_DELAY,
  localparam int CNT_W       = (CLEAR_DELAY > 0) ? $clog2(CLEAR_DELAY + 1) : 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_clear,
  input  logic i_frame_tick,
  output logic o_terminal
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           r_count <= '0;
    else if (i_clear)      r_count <= '0;
    else if (i_frame_tick) r_count <= r_count + CNT_W'(1);
  end

  // A zero delay completes immediately, without waiting for any tick.
  assign o_terminal = (CLEAR_DELAY == 0) ||
                      (i_frame_tick && (r_count == CNT_W'(CLEAR_DELAY - 1)));

endmodule

// File: rtl/stage_objective_tracker.sv
// Loads kill objectives on stage entry, tracks monsters/boss/asteroids and
// emits one win_stage pulse per stage once everything is cleared.
module stage_objective_tracker
  import game_pkg::*;
#(
  parameter int  MONSTER_COUNT = DEF_MONSTER_COUNT,
  parameter int  BOSS_HP       = DEF_BOSS_HP,
  parameter int  ASTERO_GOAL   = DEF_ASTERO_GOAL,
  parameter int  CLEAR_DELAY   = DEF_CLEAR_DELAY,
  localparam int IDX_W    = (MONSTER_COUNT > 1) ? $clog2(MONSTER_COUNT) : 1,
  localparam int BOSS_W   = $clog2(BOSS_HP + 1),
  localparam int ASTERO_W = $clog2(ASTERO_GOAL + 1)
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     i_enable_monst,
  input  logic                     i_enable_boss,
  input  logic                     i_enable_astero,
  input  stage_e                   i_stage_num,
  input  logic                     i_frame_tick,
  input  logic                     i_monster_hit,
  input  logic [IDX_W-1:0]         i_monster_hit_idx,
  input  logic                     i_boss_hit,
  input  logic                     i_astero_destroyed,
  output logic                     o_win_stage,
  output logic [MONSTER_COUNT-1:0] o_monsters_alive,
  output logic [BOSS_W-1:0]        o_boss_hp,
  output logic [ASTERO_W-1:0]      o_astero_left
);

  objective_state_e          r_state, w_next_state;
  stage_e                    r_stage;
  logic                      r_win_stage;
  logic [MONSTER_COUNT-1:0]  r_monsters_alive;
  logic [BOSS_W-1:0]         r_boss_hp;
  logic [ASTERO_W-1:0]       r_astero_left;
  logic                      w_any_en, w_stage_changed, w_done, w_delay_done;

  assign w_any_en        = i_enable_monst | i_enable_boss | i_enable_astero;
  assign w_stage_changed = (i_stage_num != r_stage);
  assign w_done          = (r_monsters_alive == '0) && (r_boss_hp == '0) &&
                           (r_astero_left == '0);

  frame_delay_counter #(.CLEAR_DELAY(CLEAR_DELAY)) u_delay (
    .clk          (clk),
    .resetN       (resetN),
    .i_clear      (r_state != S_CLEARED),
    .i_frame_tick (i_frame_tick),
    .o_terminal   (w_delay_done)
  );

  always_comb begin
    // NOTE: next state defaults to the current one so no path infers a latch.
    w_next_state = r_state;
    if ((r_state != S_IDLE) && !w_any_en) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_any_en) w_next_state = S_LOAD;
        S_LOAD:    w_next_state = S_ACTIVE;
        S_ACTIVE:  if (w_stage_changed)   w_next_state = S_LOAD;
                   else if (w_done)       w_next_state = S_CLEARED;
        S_CLEARED: if (w_stage_changed)   w_next_state = S_LOAD;
                   else if (w_delay_done) w_next_state = S_WIN;
        S_WIN:     w_next_state = S_WAIT;
        S_WAIT:    if (w_stage_changed)   w_next_state = S_LOAD;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_stage          <= INIT;
      r_win_stage      <= 1'b0;
      r_monsters_alive <= '0;
      r_boss_hp        <= '0;
      r_astero_left    <= '0;
    end else begin
      r_win_stage <= (w_next_state == S_WIN);
      case (r_state)
        S_LOAD: if (w_any_en) begin
          r_stage          <= i_stage_num;
          r_monsters_alive <= i_enable_monst  ? '1 : '0;
          r_boss_hp        <= i_enable_boss   ? BOSS_W'(BOSS_HP) : '0;
          r_astero_left    <= i_enable_astero ? ASTERO_W'(ASTERO_GOAL) : '0;
        end
        S_ACTIVE: begin
          // Out-of-range indices can occur when MONSTER_COUNT is not a power of 2.
          if (i_monster_hit && (int'(i_monster_hit_idx) < MONSTER_COUNT))
            r_monsters_alive[i_monster_hit_idx] <= 1'b0;
          if (i_boss_hit && (r_boss_hp != '0))
            r_boss_hp <= r_boss_hp - BOSS_W'(1);
          if (i_astero_destroyed && (r_astero_left != '0))
            r_astero_left <= r_astero_left - ASTERO_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_win_stage      = r_win_stage;
  assign o_monsters_alive = r_monsters_alive;
  assign o_boss_hp        = r_boss_hp;
  assign o_astero_left    = r_astero_left;

endmodule

// File: tb/tb_stage_objective_tracker.sv
// Table-driven bench with a cycle-tagged scoreboard; dut uses a 2-frame clear
// delay, dut0 the same objectives with zero delay.
module tb_stage_objective_tracker;
  import game_pkg::*;

  logic   clk = 1'b0;
  logic   resetN;
  logic   en_m, en_b, en_a, tick, mhit, bhit, adest;
  stage_e st;
  logic [1:0] midx;

  logic       win, win0;
  logic [3:0] ma, ma0;
  logic [1:0] hp, hp0;
  logic [3:0] al, al0;

  always #5 clk = ~clk;

  stage_objective_tracker #(.MONSTER_COUNT(4), .BOSS_HP(3), .ASTERO_GOAL(10),
                            .CLEAR_DELAY(2)) dut (
    .clk(clk), .resetN(resetN), .i_enable_monst(en_m), .i_enable_boss(en_b),
    .i_enable_astero(en_a), .i_stage_num(st), .i_frame_tick(tick),
    .i_monster_hit(mhit), .i_monster_hit_idx(midx), .i_boss_hit(bhit),
    .i_astero_destroyed(adest), .o_win_stage(win), .o_monsters_alive(ma),
    .o_boss_hp(hp), .o_astero_left(al));

  stage_objective_tracker #(.MONSTER_COUNT(4), .BOSS_HP(3), .ASTERO_GOAL(10),
                            .CLEAR_DELAY(0)) dut0 (
    .clk(clk), .resetN(resetN), .i_enable_monst(en_m), .i_enable_boss(en_b),
    .i_enable_astero(en_a), .i_stage_num(st), .i_frame_tick(tick),
    .i_monster_hit(mhit), .i_monster_hit_idx(midx), .i_boss_hit(bhit),
    .i_astero_destroyed(adest), .o_win_stage(win0), .o_monsters_alive(ma0),
    .o_boss_hp(hp0), .o_astero_left(al0));

  typedef struct {
    logic em, eb, ea; stage_e st; logic tick, mhit; logic [1:0] midx;
    logic bhit, adest; int reps;
    logic [3:0] ma; logic [1:0] hp; logic [3:0] al; logic win, win0;
  } vec_t;

  typedef struct {
    int due; int row;
    logic [3:0] ma; logic [1:0] hp; logic [3:0] al; logic win, win0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t sb_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(logic em, logic eb, logic ea, stage_e s,
                              logic tk, logic mh, logic [1:0] mi, logic bh,
                              logic ad, int reps, logic [3:0] e_ma,
                              logic [1:0] e_hp, logic [3:0] e_al,
                              logic e_win, logic e_win0);
    vec_t v;
    v.em = em; v.eb = eb; v.ea = ea; v.st = s; v.tick = tk; v.mhit = mh;
    v.midx = mi; v.bhit = bh; v.adest = ad; v.reps = reps;
    v.ma = e_ma; v.hp = e_hp; v.al = e_al; v.win = e_win; v.win0 = e_win0;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Expectations are tagged with the cycle whose edge should produce them.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_e = sb.pop_front();
      check("monsters_alive", sb_e.row, 32'(ma), 32'(sb_e.ma));
      check("boss_hp", sb_e.row, 32'(hp), 32'(sb_e.hp));
      check("astero_left", sb_e.row, 32'(al), 32'(sb_e.al));
      check("win_stage", sb_e.row, 32'(win), 32'(sb_e.win));
      check("win_stage_d0", sb_e.row, 32'(win0), 32'(sb_e.win0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v, input int row);
    exp_t e;
    @(negedge clk);
    en_m = v.em; en_b = v.eb; en_a = v.ea; st = v.st; tick = v.tick;
    mhit = v.mhit; midx = v.midx; bhit = v.bhit; adest = v.adest;
    e.due = cyc + 1; e.row = row; e.ma = v.ma; e.hp = v.hp; e.al = v.al;
    e.win = v.win; e.win0 = v.win0;
    sb.push_back(e);
  endtask

  initial begin
    // Monster stage 1: four kills plus a duplicate, then a 2-frame delay.
    vecs.push_back(mk(1,0,0,STAGE1, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,1,0,0,0, 1, 4'hF,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,1,0,0,0, 1, 4'hE,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,1,1,0,0, 1, 4'hC,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,1,2,0,0, 1, 4'h8,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,1,2,0,0, 1, 4'h8,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,1,3,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,0,0,0,0, 1, 4'h0,0,0, 0,1));
    vecs.push_back(mk(1,0,0,STAGE1, 1,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 1,0,0,0,0, 1, 4'h0,0,0, 1,0));
    vecs.push_back(mk(1,0,0,STAGE1, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE1, 1,1,0,0,0, 50, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE2, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,STAGE2, 0,0,0,0,0, 1, 4'hF,0,0, 0,0));
    vecs.push_back(mk(0,0,0,STAGE2, 0,0,0,0,0, 1, 4'hF,0,0, 0,0));
    vecs.push_back(mk(0,0,0,STAGE2, 1,1,1,1,1, 3, 4'hF,0,0, 0,0));
    // Boss stage 4: simultaneous hit, then saturating boss damage.
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,0,0, 1, 4'hF,0,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,0,0, 1, 4'hF,3,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,1,0,1,0, 1, 4'hE,2,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,1,1,0,0, 1, 4'hC,2,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,1,2,0,0, 1, 4'h8,2,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,1,3,0,0, 1, 4'h0,2,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,1,0, 1, 4'h0,1,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,0,0, 3, 4'h0,1,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,1,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,1,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,0,0, 1, 4'h0,0,0, 0,1));
    vecs.push_back(mk(1,1,0,STAGE4, 1,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(1,1,0,STAGE4, 1,0,0,0,0, 1, 4'h0,0,0, 1,0));
    vecs.push_back(mk(1,1,0,STAGE4, 0,0,0,0,0, 5, 4'h0,0,0, 0,0));
    // Asteroid stage 3: ten kills; dut0 wins two edges after the last one.
    vecs.push_back(mk(0,0,1,STAGE3, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(0,0,1,STAGE3, 0,0,0,0,0, 1, 4'h0,0,10, 0,0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,0,1,STAGE3, 0,0,0,0,1, 1, 4'h0,0,4'(9 - i), 0,0));
    vecs.push_back(mk(0,0,1,STAGE3, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(0,0,1,STAGE3, 0,0,0,0,0, 1, 4'h0,0,0, 0,1));
    vecs.push_back(mk(0,0,1,STAGE3, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    // Stage change while CLEARED restarts the objective.
    vecs.push_back(mk(0,0,1,STAGE1, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));
    vecs.push_back(mk(0,0,1,STAGE1, 0,0,0,0,0, 1, 4'h0,0,10, 0,0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,0,1,STAGE1, 0,0,0,0,1, 1, 4'h0,0,4'(9 - i), 0,0));
    vecs.push_back(mk(0,0,1,STAGE1, 0,0,0,0,0, 1, 4'h0,0,0, 0,0));

    resetN = 1'b0;
    en_m = 0; en_b = 0; en_a = 0; st = INIT; tick = 0;
    mhit = 0; midx = 0; bhit = 0; adest = 0;
    repeat (2) @(negedge clk);
    check("reset_monsters", -1, 32'(ma), 32'h0);
    check("reset_boss_hp", -1, 32'(hp), 32'h0);
    check("reset_astero", -1, 32'(al), 32'h0);
    check("reset_win", -1, 32'(win), 32'h0);
    resetN = 1'b1;

    for (int r = 0; r < vecs.size(); r++)
      for (int k = 0; k < vecs[r].reps; k++)
        drive(vecs[r], r);

    // Both trackers sit in CLEARED now; reset must abort without a pulse.
    @(negedge clk);
    #1;
    check("sb_drained", -1, 32'(sb.size()), 32'h0);
    resetN = 1'b0;
    #1;
    check("rst_async_win", -1, 32'(win), 32'h0);
    check("rst_async_win_d0", -1, 32'(win0), 32'h0);
    check("rst_async_astero", -1, 32'(al), 32'h0);
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_win", -1, 32'(win), 32'h0);
      check("rst_hold_win_d0", -1, 32'(win0), 32'h0);
    end
    resetN = 1'b1;
    @(negedge clk);
    check("post_rst_win", -1, 32'(win), 32'h0);
    check("post_rst_win_d0", -1, 32'(win0), 32'h0);
    check("post_rst_astero", -1, 32'(al), 32'h0);
    @(negedge clk);
    check("post_rst_reload", -1, 32'(al), 32'd10);
    check("post_rst_reload_d0", -1, 32'(al0), 32'd10);
    check("post_rst_win2", -1, 32'(win), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
